// File: rtl/if_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_pkg
// Shared constants and types for the instruction fetch stage:
//   - RESET_PC_DEFAULT : first fetch address after reset
//   - NOP_INST         : canonical NOP (addi x0, x0, 0)
//   - state_e          : fetch FSM state codes
//   - pc_sel_e         : next-PC source select used by if_pc_gen
// -----------------------------------------------------------------------------
package if_stage_pkg;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_REDIRECT = 2'd2,
    PC_RESET    = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/if_pc_gen.sv
// -----------------------------------------------------------------------------
// if_pc_gen
// Combinational next-PC multiplexer for the fetch stage.
// Ports:
//   pc_sel      in  pc_sel_e  source select (hold / +4 / redirect / reset)
//   pc          in  64        current PC register
//   redirect_pc in  64        redirect target (already alignment-processed)
//   next_pc     out 64        value to load into the PC register
// Parameter:
//   RESET_PC    reset fetch address
// -----------------------------------------------------------------------------
module if_pc_gen
  import if_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  pc_sel_e     pc_sel,
  input  logic [63:0] pc,
  input  logic [63:0] redirect_pc,
  output logic [63:0] next_pc
);

  always_comb begin
    next_pc = pc;
    unique case (pc_sel)
      PC_HOLD:     next_pc = pc;
      // Plain 64-bit add: wraps modulo 2^64 by construction.
      PC_INC:      next_pc = pc + 64'd4;
      PC_REDIRECT: next_pc = redirect_pc;
      PC_RESET:    next_pc = RESET_PC;
      default:     next_pc = pc;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Single-outstanding-request instruction fetch stage. A four-state FSM
// (IDLE -> REQ -> WAIT -> OUT) issues one fetch, captures the returned word
// and holds it for decode until accepted. Redirects from execute take
// priority over everything except reset; a redirect that arrives after a
// request has been granted marks the response for discard (kill).
//
// Ports:
//   clk            in   1   clock, rising edge
//   rst            in   1   synchronous active-high reset
//   redirect_valid in   1   taken branch/jump from execute
//   redirect_pc    in  64   redirect target
//   id_ready       in   1   decode accepts the presented instruction
//   imem_req       out  1   fetch request
//   imem_addr      out 64   fetch address (PC register; zero while idle)
//   imem_gnt       in   1   memory accepted request
//   imem_rvalid    in   1   read data valid
//   imem_rdata     in  32   fetched word
//   inst_valid     out  1   inst/inst_addr valid for decode
//   inst           out 32   registered instruction
//   inst_addr      out 64   registered PC of inst
//   inst_misalign  out  1   (IF_MISALIGN_CHK_EN only) misaligned redirect marker
//
// Build option IF_MISALIGN_CHK_EN: when defined, a redirect to an address with
// bits [1:0] != 0 does not fetch; a NOP tagged with inst_misalign is presented
// instead. When undefined, the low two redirect bits are forced to zero.
// -----------------------------------------------------------------------------
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        id_ready,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_addr
`ifdef IF_MISALIGN_CHK_EN
  ,
  output logic        inst_misalign
`endif
);

  state_e      state_reg, state_next;
  logic [63:0] pc_reg, pc_next;
  logic        kill_reg, kill_next;
  logic [31:0] inst_reg, inst_next;
  logic [63:0] inst_addr_reg, inst_addr_next;
  logic        misalign_reg, misalign_next;
  pc_sel_e     pc_sel;
  logic [63:0] redirect_target;
  logic        redirect_misaligned;

`ifdef IF_MISALIGN_CHK_EN
  assign redirect_target     = redirect_pc;
  assign redirect_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign redirect_target     = redirect_pc & ~64'h3;
  assign redirect_misaligned = 1'b0;
`endif

  if_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .pc_sel      (pc_sel),
    .pc          (pc_reg),
    .redirect_pc (redirect_target),
    .next_pc     (pc_next)
  );

  always_comb begin
    state_next     = state_reg;
    kill_next      = kill_reg;
    pc_sel         = PC_HOLD;
    inst_next      = inst_reg;
    inst_addr_next = inst_addr_reg;
    misalign_next  = misalign_reg;

    if (rst) begin
      pc_sel = PC_RESET;
    end else if (redirect_misaligned) begin
      // Present a NOP flagged as misaligned instead of fetching. Any response
      // still in flight lands outside WAIT and is therefore ignored.
      pc_sel         = PC_REDIRECT;
      state_next     = S_OUT;
      kill_next      = 1'b0;
      inst_next      = NOP_INST;
      inst_addr_next = redirect_target;
      misalign_next  = 1'b1;
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          state_next = S_REQ;
          if (redirect_valid) pc_sel = PC_REDIRECT;
        end
        S_REQ: begin
          if (redirect_valid) pc_sel = PC_REDIRECT;
          if (imem_gnt) begin
            state_next = S_WAIT;
            // The granted request is for the old PC; drop its response.
            kill_next  = redirect_valid;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (redirect_valid || kill_reg) begin
              if (redirect_valid) pc_sel = PC_REDIRECT;
              kill_next  = 1'b0;
              state_next = S_REQ;
            end else begin
              inst_next      = imem_rdata;
              inst_addr_next = pc_reg;
              state_next     = S_OUT;
            end
          end else if (redirect_valid) begin
            pc_sel    = PC_REDIRECT;
            kill_next = 1'b1;
          end
        end
        S_OUT: begin
          if (redirect_valid) begin
            pc_sel        = PC_REDIRECT;
            state_next    = S_REQ;
            misalign_next = 1'b0;
          end else if (id_ready) begin
            pc_sel        = PC_INC;
            state_next    = S_REQ;
            misalign_next = 1'b0;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    pc_reg <= pc_next;
    if (rst) begin
      state_reg     <= S_IDLE;
      kill_reg      <= 1'b0;
      inst_reg      <= 32'd0;
      inst_addr_reg <= 64'd0;
      misalign_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      kill_reg      <= kill_next;
      inst_reg      <= inst_next;
      inst_addr_reg <= inst_addr_next;
      misalign_reg  <= misalign_next;
    end
  end

  assign imem_req   = (state_reg == S_REQ);
  assign imem_addr  = (state_reg == S_IDLE) ? 64'd0 : pc_reg;
  assign inst_valid = (state_reg == S_OUT);
  assign inst       = inst_reg;
  assign inst_addr  = inst_addr_reg;

`ifdef IF_MISALIGN_CHK_EN
  assign inst_misalign = misalign_reg;
`else
  // misalign_reg is never set in this build; keep it referenced.
  logic unused_misalign;
  assign unused_misalign = misalign_reg;
`endif

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Directed-vector testbench for if_stage. Inputs change 1 ns after the rising
// edge; outputs are checked at that same point, reflecting the state loaded
// by the edge just taken.
// -----------------------------------------------------------------------------
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_ready;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_addr;
`ifdef IF_MISALIGN_CHK_EN
  logic        inst_misalign;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_addr      (inst_addr)
`ifdef IF_MISALIGN_CHK_EN
    ,
    .inst_misalign  (inst_misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-14s got=%h", tag, got);
    end else begin
      $display("FAIL %-14s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    id_ready       = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'd0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    // Reset state
    check("rst_req",    imem_req,   1'b0);
    check("rst_valid",  inst_valid, 1'b0);
    check("rst_inst",   inst,       32'd0);
    check("rst_iaddr",  inst_addr,  64'd0);

    // Reset release: IDLE, then REQ at RESET_PC
    rst = 1'b0;
    step();                                 // IDLE -> REQ
    check("req_first",  imem_req,  1'b1);
    check("addr_first", imem_addr, 64'h8000_0000);
    imem_gnt = 1'b1;
    step();                                 // REQ -> WAIT
    check("wait_req",   imem_req,   1'b0);
    check("wait_valid", inst_valid, 1'b0);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0513;
    step();                                 // WAIT -> OUT
    check("out_valid",  inst_valid, 1'b1);
    check("out_inst",   inst,       32'h0000_0513);
    check("out_iaddr",  inst_addr,  64'h8000_0000);

    // Stall 5 cycles; a stray rvalid during OUT must be ignored
    imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      imem_rvalid = (i == 2);
      imem_rdata  = 32'hDEAD_BEEF;
      step();
      check("stall_valid", inst_valid, 1'b1);
      check("stall_inst",  inst,       32'h0000_0513);
      check("stall_iaddr", inst_addr,  64'h8000_0000);
      check("stall_req",   imem_req,   1'b0);
    end
    imem_rvalid = 1'b0;
    id_ready = 1'b1;
    step();                                 // OUT -> REQ, pc+4
    check("acc_valid",  inst_valid, 1'b0);
    check("acc_addr",   imem_addr,  64'h8000_0004);
    check("acc_req",    imem_req,   1'b1);

    // Redirect while in WAIT, response 3 cycles later dropped
    id_ready = 1'b0; imem_gnt = 1'b1;
    step();                                 // -> WAIT
    imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
    step();                                 // WAIT, kill set
    redirect_valid = 1'b0;
    check("wk_req",     imem_req, 1'b0);
    step();
    check("wk_valid1",  inst_valid, 1'b0);
    step();
    check("wk_valid2",  inst_valid, 1'b0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();                                 // discarded -> REQ
    imem_rvalid = 1'b0;
    check("wk_valid3",  inst_valid, 1'b0);
    check("wk_req2",    imem_req,   1'b1);
    check("wk_addr",    imem_addr,  64'h8000_0100);

    // Fetch at 0x80000100, then redirect in OUT with id_ready=1
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0010_0093;
    step();
    imem_rvalid = 1'b0;
    check("f2_inst",    inst,      32'h0010_0093);
    check("f2_iaddr",   inst_addr, 64'h8000_0100);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0200; id_ready = 1'b1;
    step();
    redirect_valid = 1'b0; id_ready = 1'b0;
    check("ro_valid",   inst_valid, 1'b0);
    check("ro_addr",    imem_addr,  64'h8000_0200);

    // Redirect coincident with grant: response killed
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0300; imem_gnt = 1'b1;
    step();
    redirect_valid = 1'b0; imem_gnt = 1'b0;
    check("rg_req",     imem_req, 1'b0);
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
    step();
    imem_rvalid = 1'b0;
    check("rg_valid",   inst_valid, 1'b0);
    check("rg_addr",    imem_addr,  64'h8000_0300);

    // Redirect in REQ without grant
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0400;
    step();
    redirect_valid = 1'b0;
    check("rr_req",     imem_req,  1'b1);
    check("rr_addr",    imem_addr, 64'h8000_0400);

    // Redirect coincident with rvalid in WAIT
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0500;
    imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
    step();
    redirect_valid = 1'b0; imem_rvalid = 1'b0;
    check("rv_valid",   inst_valid, 1'b0);
    check("rv_addr",    imem_addr,  64'h8000_0500);

    // Stray rvalid in REQ ignored
    imem_rvalid = 1'b1;
    step();
    imem_rvalid = 1'b0;
    check("rq_stray",   imem_req,   1'b1);
    check("rq_valid",   inst_valid, 1'b0);

    // PC wrap: fetch at 0xFFFF_FFFF_FFFF_FFFC, accept -> 0
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("wr_addr",    imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
    step();
    imem_rvalid = 1'b0;
    check("wr_iaddr",   inst_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    check("wr_next",    imem_addr, 64'd0);

    // Misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0002;
    step();
    redirect_valid = 1'b0;
`ifdef IF_MISALIGN_CHK_EN
    check("ma_valid",   inst_valid,    1'b1);
    check("ma_flag",    inst_misalign, 1'b1);
    check("ma_inst",    inst,          32'h0000_0013);
    check("ma_iaddr",   inst_addr,     64'h8000_0002);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    check("ma_clear",   inst_misalign, 1'b0);
`else
    check("ma_req",     imem_req,  1'b1);
    check("ma_addr",    imem_addr, 64'h8000_0000);
`endif

    // Reset dominates redirect
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_0700;
    step();
    check("rd_req",     imem_req,   1'b0);
    check("rd_valid",   inst_valid, 1'b0);
    // Redirect in IDLE
    rst = 1'b0; redirect_pc = 64'h8000_0800;
    step();
    redirect_valid = 1'b0;
    check("ri_req",     imem_req,  1'b1);
    check("ri_addr",    imem_addr, 64'h8000_0800);

    // Reset while presenting an instruction clears it and restores RESET_PC
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333;
    step();
    imem_rvalid = 1'b0;
    check("ro2_valid",  inst_valid, 1'b1);
    rst = 1'b1;
    step();
    check("rs_valid",   inst_valid, 1'b0);
    check("rs_inst",    inst,       32'd0);
    check("rs_iaddr",   inst_addr,  64'd0);
    rst = 1'b0;
    step();
    check("rs_addr",    imem_addr, 64'h8000_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
